cdb_writeback: RTL

Result-side stage downstream of the functional units (int ALU, FP ALU, AGU) in the dynamic pipeline. Each unit's result (tag, data, rd) goes into a small per-source buffer. A round-robin arbiter grants one buffered result per cycle onto the registered common data bus (CDB). The same granted result drives the architectural register-file write port. The dispatcher reservation stations consume the CDB; the register array consumes the write port.

---
 rtl/cdb_writeback_pkg.sv | 29 ++
 rtl/cdb_writeback_if.sv | 16 +
 rtl/cdb_writeback_wb_fifo.sv | 55 +++++
 rtl/cdb_writeback.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cdb_writeback_pkg.sv
// Shared definitions for the result writeback stage: source indices, entry layout
// and default widths shared with the dispatcher.
package cdb_writeback_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int ID_WIDTH_DEF = 4;
  localparam int RD_WIDTH     = 5;
  localparam int NUM_SRC      = 3;

  localparam logic [1:0] SRC_ALU   = 2'd0;
  localparam logic [1:0] SRC_FPALU = 2'd1;
  localparam logic [1:0] SRC_AGU   = 2'd2;

  // Buffered result layout, most significant field first: {tag, rd, data}
  typedef struct packed {
    logic [ID_WIDTH_DEF-1:0] tag;
    logic [RD_WIDTH-1:0]     rd;
    logic [XLEN_DEF-1:0]     data;
  } wb_entry_t;

  function automatic int entry_width(input int xlen, input int id_width);
    return id_width + RD_WIDTH + xlen;
  endfunction

  function automatic logic [1:0] next_src(input logic [1:0] src);
    return (src == SRC_AGU) ? SRC_ALU : src + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_writeback_if.sv
// Result handshake from one functional unit into the writeback stage.
interface cdb_writeback_if
  import cdb_writeback_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ID_WIDTH = ID_WIDTH_DEF
);
  logic                valid;
  logic [ID_WIDTH-1:0] tag;
  logic [XLEN-1:0]     data;
  logic [RD_WIDTH-1:0] rd;
  logic                ready;

  modport master (output valid, tag, data, rd, input ready);
  modport slave  (input valid, tag, data, rd, output ready);
endinterface

// File: rtl/cdb_writeback_wb_fifo.sv
// Small synchronous FIFO holding one functional unit's pending results.
module wb_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_writeback.sv
// Buffers ALU/FP/AGU results and round-robin grants one per cycle onto the
// registered CDB and the register-file write port.
module cdb_writeback
  import cdb_writeback_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ID_WIDTH  = ID_WIDTH_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush_i,
  cdb_writeback_if.slave      alu,
  cdb_writeback_if.slave      fpalu,
  cdb_writeback_if.slave      agu,
  output logic                cdb_valid,
  output logic [ID_WIDTH-1:0] cdb_tag,
  output logic [XLEN-1:0]     cdb_data,
  output logic                rf_we,
  output logic [RD_WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [ID_WIDTH-1:0] rf_wtag
);
  localparam int EW = entry_width(XLEN, ID_WIDTH);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [EW-1:0]      push_data [NUM_SRC];
  logic [EW-1:0]      head      [NUM_SRC];
  logic [CW-1:0]      count     [NUM_SRC];
  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] empty;

  logic [1:0]          rr_ptr;
  logic                grant_any;
  logic [1:0]          grant_src;
  logic [1:0]          probe;
  logic [EW-1:0]       grant_entry;
  logic [ID_WIDTH-1:0] g_tag;
  logic [RD_WIDTH-1:0] g_rd;
  logic [XLEN-1:0]     g_data;

  assign push_data[SRC_ALU]   = {alu.tag,   alu.rd,   alu.data};
  assign push_data[SRC_FPALU] = {fpalu.tag, fpalu.rd, fpalu.data};
  assign push_data[SRC_AGU]   = {agu.tag,   agu.rd,   agu.data};
  assign src_valid            = {agu.valid, fpalu.valid, alu.valid};

  assign alu.ready   = ready[SRC_ALU];
  assign fpalu.ready = ready[SRC_FPALU];
  assign agu.ready   = ready[SRC_AGU];

  // Ready depends on occupancy only, so a full buffer refuses even when popped
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign ready[k] = (count[k] < CW'(BUF_DEPTH));
    assign push[k]  = src_valid[k] && ready[k] && !flush_i;

    wb_fifo #(
      .WIDTH (EW),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush_i),
      .push   (push[k]),
      .pop    (pop[k]),
      .din    (push_data[k]),
      .dout   (head[k]),
      .empty  (empty[k]),
      .count  (count[k])
    );
  end

  // Round-robin search over non-empty heads, starting at the pointer
  always_comb begin
    grant_any = 1'b0;
    grant_src = rr_ptr;
    probe     = rr_ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_any && !empty[probe]) begin
        grant_any = 1'b1;
        grant_src = probe;
      end
      probe = next_src(probe);
    end
  end

  always_comb begin
    pop = '0;
    if (grant_any && !flush_i) begin
      pop[grant_src] = 1'b1;
    end
  end

  assign grant_entry = head[grant_src];
  assign g_tag       = grant_entry[EW-1 -: ID_WIDTH];
  assign g_rd        = grant_entry[XLEN +: RD_WIDTH];
  assign g_data      = grant_entry[XLEN-1:0];

  // Idle and flush cycles keep the payload fields, only the strobes drop
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr    <= SRC_ALU;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rf_wtag   <= '0;
    end else if (flush_i) begin
      cdb_valid <= 1'b0;
      rf_we     <= 1'b0;
    end else if (grant_any) begin
      rr_ptr    <= next_src(grant_src);
      cdb_valid <= 1'b1;
      cdb_tag   <= g_tag;
      cdb_data  <= g_data;
      rf_we     <= (g_rd != '0);
      rf_waddr  <= g_rd;
      rf_wdata  <= g_data;
      rf_wtag   <= g_tag;
    end else begin
      cdb_valid <= 1'b0;
      rf_we     <= 1'b0;
    end
  end

endmodule
